// File: rtl/i2c_reg_arbiter.sv
// Round-robin arbiter/sequencer sharing the I2C core register bus among NUM_REQ requesters.
// Each grant runs SETUP -> STROBE -> WAIT -> DONE, with every output registered.
module i2c_reg_arbiter #(
    parameter int unsigned NUM_REQ = 2,
    parameter int unsigned AW      = 6,
    parameter int unsigned DW      = 8
) (
    input  logic                  i_sysclk,
    input  logic                  i_reset,
    input  logic [NUM_REQ-1:0]    i_req,
    input  logic [NUM_REQ-1:0]    i_wr,
    input  logic [NUM_REQ*AW-1:0] i_addr,
    input  logic [NUM_REQ*DW-1:0] i_wdata,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic [NUM_REQ-1:0]    o_ack,
    output logic [DW-1:0]         o_rdata,
    output logic                  o_busy,
    output logic                  o_wr_ena,
    output logic [AW-1:0]         o_wr_addr,
    output logic [DW-1:0]         o_wr_data,
    output logic                  o_rd_ena,
    output logic [AW-1:0]         o_rd_addr,
    input  logic [DW-1:0]         i_rd_data
);

    localparam int unsigned PW  = $clog2(NUM_REQ);
    localparam int unsigned AIW = $clog2(NUM_REQ * AW);
    localparam int unsigned DIW = $clog2(NUM_REQ * DW);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_WAIT,
        ST_DONE
    } state_t;

    state_t               state, state_nxt;
    logic [PW-1:0]        ptr;
    logic [PW-1:0]        win_idx;
    logic                 win_wr;
    logic                 pick_vld;
    logic [PW-1:0]        pick_idx;
    logic [NUM_REQ-1:0]   pick_oh;
    logic [NUM_REQ-1:0]   win_oh;
    logic [AW-1:0]        sel_addr;
    logic [DW-1:0]        sel_wdata;
    logic                 sel_wr;

    // Round robin: first requesting index scanning upward from ptr with wrap.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
            if (i_req[PW'((int'(ptr) + i) % int'(NUM_REQ))]) begin
                pick_vld = 1'b1;
                pick_idx = PW'((int'(ptr) + i) % int'(NUM_REQ));
            end
        end
    end

    always_comb begin
        pick_oh = '0;
        win_oh  = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            pick_oh[i] = (pick_idx == PW'(i));
            win_oh[i]  = (win_idx == PW'(i));
        end
    end

    assign sel_addr  = i_addr[AIW'(int'(pick_idx) * int'(AW)) +: AW];
    assign sel_wdata = i_wdata[DIW'(int'(pick_idx) * int'(DW)) +: DW];
    assign sel_wr    = i_wr[pick_idx];

    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (pick_vld) state_nxt = ST_SETUP;
            ST_SETUP:  state_nxt = ST_STROBE;
            ST_STROBE: state_nxt = ST_WAIT;
            ST_WAIT:   state_nxt = ST_DONE;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Output and transaction registers; bus address/data hold when not driven.
    always_ff @(posedge i_sysclk) begin
        if (i_reset) begin
            ptr       <= '0;
            win_idx   <= '0;
            win_wr    <= 1'b0;
            o_grant   <= '0;
            o_ack     <= '0;
            o_rdata   <= '0;
            o_busy    <= 1'b0;
            o_wr_ena  <= 1'b0;
            o_wr_addr <= '0;
            o_wr_data <= '0;
            o_rd_ena  <= 1'b0;
            o_rd_addr <= '0;
        end else begin
            o_busy <= (state_nxt != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (pick_vld) begin
                        win_idx <= pick_idx;
                        win_wr  <= sel_wr;
                        o_grant <= pick_oh;
                        if (sel_wr) begin
                            o_wr_addr <= sel_addr;
                            o_wr_data <= sel_wdata;
                        end else begin
                            o_rd_addr <= sel_addr;
                        end
                    end
                end
                ST_SETUP: begin
                    o_wr_ena <= win_wr;
                    o_rd_ena <= !win_wr;
                end
                ST_STROBE: begin
                    o_wr_ena <= 1'b0;
                    o_rd_ena <= 1'b0;
                end
                ST_WAIT: begin
                    if (!win_wr) o_rdata <= i_rd_data;
                    o_ack <= win_oh;
                end
                ST_DONE: begin
                    o_ack   <= '0;
                    o_grant <= '0;
                    ptr     <= (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                end
                default: begin
                    o_wr_ena <= 1'b0;
                    o_rd_ena <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// Directed self-checking bench for i2c_reg_arbiter (NUM_REQ = 2 and NUM_REQ = 4 instances).
module tb_i2c_reg_arbiter;

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [1:0]  req = '0, wr = '0;
    logic [11:0] addr = '0;
    logic [15:0] wdata = '0;
    logic [1:0]  grant, ack;
    logic [7:0]  rdata, wr_data, rd_data = '0;
    logic        busy, wr_ena, rd_ena;
    logic [5:0]  wr_addr, rd_addr;

    logic [3:0]  req4 = '0, wr4 = '0;
    logic [23:0] addr4 = '0;
    logic [31:0] wdata4 = '0;
    logic [3:0]  grant4, ack4;
    logic [7:0]  rdata4, wr_data4, rd_data4 = '0;
    logic        busy4, wr_ena4, rd_ena4;
    logic [5:0]  wr_addr4, rd_addr4;

    i2c_reg_arbiter #(.NUM_REQ(2), .AW(AW), .DW(DW)) dut (
        .i_sysclk(clk), .i_reset(rst), .i_req(req), .i_wr(wr), .i_addr(addr),
        .i_wdata(wdata), .o_grant(grant), .o_ack(ack), .o_rdata(rdata),
        .o_busy(busy), .o_wr_ena(wr_ena), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_rd_ena(rd_ena), .o_rd_addr(rd_addr), .i_rd_data(rd_data)
    );

    i2c_reg_arbiter #(.NUM_REQ(4), .AW(AW), .DW(DW)) dut4 (
        .i_sysclk(clk), .i_reset(rst), .i_req(req4), .i_wr(wr4), .i_addr(addr4),
        .i_wdata(wdata4), .o_grant(grant4), .o_ack(ack4), .o_rdata(rdata4),
        .o_busy(busy4), .o_wr_ena(wr_ena4), .o_wr_addr(wr_addr4), .o_wr_data(wr_data4),
        .o_rd_ena(rd_ena4), .o_rd_addr(rd_addr4), .i_rd_data(rd_data4)
    );

    // Register file model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (rd_ena)  rd_data  <= {2'b00, rd_addr} ^ 8'h39;
        if (rd_ena4) rd_data4 <= {2'b00, rd_addr4} ^ 8'h39;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 10) begin
            tick();
            n++;
        end
        chk(tag, 32'(busy), 0);
    endtask

    initial begin
        int n_ack;
        int ack_who[5];
        int ack_cyc[5];
        int rr[4];
        int overlap;

        // Reset
        rst = 1'b1;
        tick(); tick();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant", 32'(grant), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_enas", 32'({wr_ena, rd_ena}), 0);
        chk("rst_bus", 32'({wr_addr, wr_data, rd_addr, rdata}), 0);
        chk("rst_dut4", 32'({busy4, grant4, ack4, wr_ena4, rd_ena4}), 0);
        rst = 1'b0;
        tick();

        // Single write, requester 0
        req = 2'b01; wr = 2'b01; addr = {6'h00, 6'h12}; wdata = {8'h00, 8'hA5};
        tick();
        chk("wr_c1_grant", 32'(grant), 'h1);
        chk("wr_c1_busy", 32'(busy), 1);
        chk("wr_c1_enas", 32'({wr_ena, rd_ena}), 0);
        chk("wr_c1_bus", 32'({wr_addr, wr_data}), 32'({6'h12, 8'hA5}));
        tick();
        chk("wr_c2_enas", 32'({wr_ena, rd_ena}), 'b10);
        chk("wr_c2_bus", 32'({wr_addr, wr_data}), 32'({6'h12, 8'hA5}));
        tick();
        chk("wr_c3_enas", 32'({wr_ena, rd_ena}), 0);
        chk("wr_c3_ack", 32'(ack), 0);
        tick();
        chk("wr_c4_ack", 32'(ack), 'h1);
        chk("wr_c4_rdata", 32'(rdata), 0);
        req = 2'b00;
        tick();
        chk("wr_c5_idle", 32'({busy, grant, ack}), 0);

        // Single read, requester 1
        req = 2'b10; wr = 2'b00; addr = {6'h05, 6'h00};
        tick();
        chk("rd_c1_grant", 32'(grant), 'h2);
        chk("rd_c1_addr", 32'(rd_addr), 'h05);
        chk("rd_c1_enas", 32'({wr_ena, rd_ena}), 0);
        tick();
        chk("rd_c2_enas", 32'({wr_ena, rd_ena}), 'b01);
        tick();
        chk("rd_c3_enas", 32'({wr_ena, rd_ena}), 0);
        tick();
        chk("rd_c4_ack", 32'(ack), 'h2);
        chk("rd_c4_rdata", 32'(rdata), 'h3C);
        req = 2'b00;
        tick();
        chk("rd_c5_ack", 32'(ack), 0);
        tick();
        chk("rd_hold_rdata", 32'(rdata), 'h3C);

        // Input change after grant is ignored
        req = 2'b01; wr = 2'b01; addr = {6'h00, 6'h0A}; wdata = {8'h00, 8'h11};
        tick();
        addr = {6'h00, 6'h3F}; wdata = {8'h00, 8'hFF};
        tick();
        chk("chg_strobe", 32'({wr_ena, wr_addr, wr_data}), 32'({1'b1, 6'h0A, 8'h11}));
        tick(); tick();
        chk("chg_ack", 32'(ack), 'h1);
        chk("chg_rdata_kept", 32'(rdata), 'h3C);
        req = 2'b00;
        tick();

        // Contention after reset: order 0,1,0,1 with 5-cycle spacing
        rst = 1'b1; tick(); rst = 1'b0;
        req = 2'b11; wr = 2'b11; addr = {6'h21, 6'h20}; wdata = 16'h2211;
        n_ack = 0; rr[0] = 0; rr[1] = 0;
        for (int c = 1; c <= 40 && n_ack < 4; c++) begin
            tick();
            for (int b = 0; b < 2; b++) begin
                if (rr[b] > 0) begin
                    rr[b]--;
                    if (rr[b] == 0) req[b] = 1'b1;
                end
            end
            if (ack != 2'b00) begin
                ack_who[n_ack] = ack[1] ? 1 : 0;
                ack_cyc[n_ack] = c;
                n_ack++;
                for (int b = 0; b < 2; b++) begin
                    if (ack[b]) begin
                        req[b] = 1'b0;
                        rr[b] = 2;
                    end
                end
            end
        end
        req = 2'b00;
        chk("cont_n_ack", 32'(n_ack), 4);
        if (n_ack == 4) begin
            chk("cont_first_cyc", 32'(ack_cyc[0]), 4);
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("cont_order%0d", k), 32'(ack_who[k]), 32'(k % 2));
                if (k > 0) chk($sformatf("cont_space%0d", k), 32'(ack_cyc[k] - ack_cyc[k-1]), 5);
            end
        end
        wait_idle("cont_drain");

        // Complete a requester-0 write so the pointer moves to 1
        req = 2'b01; wr = 2'b01;
        tick(); tick(); tick(); tick();
        chk("ptr_set_ack", 32'(ack), 'h1);
        req = 2'b00;
        tick();

        // Reset during the strobe cycle
        req = 2'b01; wr = 2'b01; addr = {6'h00, 6'h2A}; wdata = {8'h00, 8'h77};
        tick(); tick();
        chk("rstmid_strobe", 32'({wr_ena, wr_addr, wr_data}), 32'({1'b1, 6'h2A, 8'h77}));
        rst = 1'b1; req = 2'b00;
        tick();
        chk("rstmid_ctrl", 32'({busy, grant, ack, wr_ena, rd_ena}), 0);
        chk("rstmid_bus", 32'({wr_addr, wr_data, rd_addr, rdata}), 0);
        rst = 1'b0;
        tick();
        chk("rstmid_no_ack", 32'({busy, ack}), 0);
        req = 2'b11; wr = 2'b11;
        tick();
        chk("rstmid_ptr0_grant", 32'(grant), 'h1);
        tick(); tick(); tick();
        chk("rstmid_fresh_ack", 32'(ack), 'h1);
        req = 2'b00;
        wait_idle("rstmid_drain");

        // Fairness with four requesters, mixed reads and writes
        req4 = 4'hF; wr4 = 4'b0101;
        addr4 = {6'h33, 6'h22, 6'h11, 6'h01}; wdata4 = 32'h44332211;
        n_ack = 0; overlap = 0;
        for (int b = 0; b < 4; b++) rr[b] = 0;
        for (int c = 1; c <= 60 && n_ack < 5; c++) begin
            tick();
            if (wr_ena4 && rd_ena4) overlap++;
            for (int b = 0; b < 4; b++) begin
                if (rr[b] > 0) begin
                    rr[b]--;
                    if (rr[b] == 0) req4[b] = 1'b1;
                end
            end
            if (ack4 != 4'h0) begin
                for (int b = 0; b < 4; b++) begin
                    if (ack4[b]) begin
                        ack_who[n_ack] = b;
                        req4[b] = 1'b0;
                        rr[b] = 2;
                    end
                end
                n_ack++;
            end
        end
        req4 = 4'h0;
        chk("fair_n_ack", 32'(n_ack), 5);
        if (n_ack == 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("fair_order%0d", k), 32'(ack_who[k]), 32'(k % 4));
            end
        end
        chk("fair_no_overlap", 32'(overlap), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
